// File: rtl/compare_debounce.sv
// ============================================================================
//  Module   : compare_debounce
//  Purpose  : Debounces one-hot GT/LT/EQ comparator flags into a committed result.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module compare_debounce #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    input  logic             gt,
    input  logic             lt,
    input  logic             eq,
    output logic [1:0]       out_state,
    output logic             out_changed,
    output logic             err,
    output logic [CNT_W-1:0] change_count
);

    typedef enum logic [1:0] {
        ST_UNSET  = 2'd0,
        ST_CAND   = 2'd1,
        ST_STABLE = 2'd2
    } state_t;

    localparam logic [1:0]       c_code_eq   = 2'b00;
    localparam logic [1:0]       c_code_gt   = 2'b01;
    localparam logic [1:0]       c_code_lt   = 2'b10;
    localparam logic [1:0]       c_code_none = 2'b11;
    localparam logic [3:0]       c_depth     = 4'(DEPTH);
    localparam logic [CNT_W-1:0] c_cnt_max   = '1;

    state_t           r_state;
    logic [1:0]       r_cand;
    logic [3:0]       r_run;
    logic [1:0]       r_out_state;
    logic             r_changed;
    logic             r_err;
    logic [CNT_W-1:0] r_count;

    state_t           w_state_nxt;
    logic [1:0]       w_cand_nxt;
    logic [3:0]       w_run_nxt;
    logic [1:0]       w_out_nxt;
    logic             w_changed_nxt;
    logic             w_err_nxt;
    logic [CNT_W-1:0] w_count_nxt;

    logic [1:0]       w_code;
    logic             w_well_formed;
    logic [3:0]       w_run_inc;

    always_comb begin
        w_code        = c_code_none;
        w_well_formed = 1'b1;
        case ({gt, lt, eq})
            3'b001:  w_code = c_code_eq;
            3'b100:  w_code = c_code_gt;
            3'b010:  w_code = c_code_lt;
            default: w_well_formed = 1'b0;
        endcase
    end

    assign w_run_inc = r_run + 4'd1;

    // The committed code doubles as "nothing committed" (11), which no
    // well-formed sample can ever match.
    always_comb begin
        w_state_nxt   = r_state;
        w_cand_nxt    = r_cand;
        w_run_nxt     = r_run;
        w_out_nxt     = r_out_state;
        w_changed_nxt = 1'b0;
        w_err_nxt     = 1'b0;
        w_count_nxt   = r_count;

        if (in_valid) begin
            if (!w_well_formed) begin
                w_err_nxt   = 1'b1;
                w_run_nxt   = 4'd0;
                w_state_nxt = (r_out_state == c_code_none) ? ST_UNSET : ST_STABLE;
            end else begin
                case (r_state)
                    ST_UNSET: begin
                        w_cand_nxt  = w_code;
                        w_run_nxt   = 4'd1;
                        w_state_nxt = ST_CAND;
                    end
                    ST_CAND: begin
                        if (w_code == r_cand) begin
                            if (w_run_inc == c_depth) begin
                                w_out_nxt     = r_cand;
                                w_run_nxt     = 4'd0;
                                w_state_nxt   = ST_STABLE;
                                w_changed_nxt = 1'b1;
                                if (r_count != c_cnt_max) begin
                                    w_count_nxt = r_count + CNT_W'(1);
                                end
                            end else begin
                                w_run_nxt = w_run_inc;
                            end
                        end else if (w_code == r_out_state) begin
                            w_run_nxt   = 4'd0;
                            w_state_nxt = ST_STABLE;
                        end else begin
                            w_cand_nxt = w_code;
                            w_run_nxt  = 4'd1;
                        end
                    end
                    ST_STABLE: begin
                        if (w_code != r_out_state) begin
                            w_cand_nxt  = w_code;
                            w_run_nxt   = 4'd1;
                            w_state_nxt = ST_CAND;
                        end
                    end
                    default: begin
                        w_state_nxt = ST_UNSET;
                        w_run_nxt   = 4'd0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_UNSET;
            r_cand      <= c_code_none;
            r_run       <= 4'd0;
            r_out_state <= c_code_none;
            r_changed   <= 1'b0;
            r_err       <= 1'b0;
            r_count     <= '0;
        end else if (clear) begin
            r_state     <= ST_UNSET;
            r_cand      <= c_code_none;
            r_run       <= 4'd0;
            r_out_state <= c_code_none;
            r_changed   <= 1'b0;
            r_err       <= 1'b0;
            r_count     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cand      <= w_cand_nxt;
            r_run       <= w_run_nxt;
            r_out_state <= w_out_nxt;
            r_changed   <= w_changed_nxt;
            r_err       <= w_err_nxt;
            r_count     <= w_count_nxt;
        end
    end

    assign out_state    = r_out_state;
    assign out_changed  = r_changed;
    assign err          = r_err;
    assign change_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_compare_debounce.sv
// ============================================================================
//  Module   : tb_compare_debounce
//  Purpose  : Scoreboard bench for compare_debounce (DEPTH=4, CNT_W=2).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_compare_debounce;

    localparam int          DEPTH = 4;
    localparam int          CNT_W = 2;
    localparam logic [2:0]  c_eq  = 3'b001;
    localparam logic [2:0]  c_gt  = 3'b100;
    localparam logic [2:0]  c_lt  = 3'b010;

    logic             clk;
    logic             rst_n;
    logic             clear;
    logic             in_valid;
    logic             gt;
    logic             lt;
    logic             eq;
    logic [1:0]       out_state;
    logic             out_changed;
    logic             err;
    logic [CNT_W-1:0] change_count;

    typedef struct packed {
        logic       is_err;
        logic [1:0] st;
        logic [1:0] cnt;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    compare_debounce #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (clear),
        .in_valid     (in_valid),
        .gt           (gt),
        .lt           (lt),
        .eq           (eq),
        .out_state    (out_state),
        .out_changed  (out_changed),
        .err          (err),
        .change_count (change_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic push(input logic is_err, input logic [1:0] st, input logic [1:0] cnt);
        exp_t e;
        e.is_err = is_err;
        e.st     = st;
        e.cnt    = cnt;
        q.push_back(e);
    endtask

    task automatic smp(input logic [2:0] v);
        @(negedge clk);
        in_valid    = 1'b1;
        clear       = 1'b0;
        {gt, lt, eq} = v;
    endtask

    task automatic settle(input string name, input logic [1:0] st, input logic [1:0] cnt);
        @(negedge clk);
        in_valid = 1'b0;
        chk({name, "_state"}, int'(out_state), int'(st));
        chk({name, "_count"}, int'(change_count), int'(cnt));
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0;
        clear    = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: every pulse must match the next scoreboard entry.
    always @(negedge clk) begin
        if (rst_n && (out_changed || err)) begin
            if (q.size() == 0) begin
                n_checks++;
                $display("FAIL spurious_pulse: got changed=%0b err=%0b expected none (t=%0t)",
                         out_changed, err, $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("pulse_kind", int'({out_changed, err}), e.is_err ? 1 : 2);
                chk("pulse_state", int'(out_state), int'(e.st));
                chk("pulse_count", int'(change_count), int'(e.cnt));
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        clear    = 1'b0;
        in_valid = 1'b0;
        {gt, lt, eq} = 3'b000;
        repeat (2) @(negedge clk);
        chk("rst_state", int'(out_state), 3);
        chk("rst_changed", int'(out_changed), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_count", int'(change_count), 0);
        rst_n = 1'b1;

        // First commit out of UNSET
        repeat (3) smp(c_eq);
        settle("eq3", 2'b11, 2'd0);
        smp(c_eq); push(1'b0, 2'b00, 2'd1);
        settle("eq4", 2'b00, 2'd1);

        // Candidate abandoned by a return to the committed code
        repeat (3) smp(c_gt);
        settle("gt3", 2'b00, 2'd1);
        smp(c_eq);
        settle("abandon", 2'b00, 2'd1);
        repeat (3) smp(c_gt);
        settle("gt3b", 2'b00, 2'd1);
        smp(c_gt); push(1'b0, 2'b01, 2'd2);
        settle("gt4", 2'b01, 2'd2);

        // in_valid gaps do not break a run
        do_reset();
        repeat (2) smp(c_gt);
        settle("gap_a", 2'b11, 2'd0);
        repeat (4) settle("gap_hold", 2'b11, 2'd0);
        smp(c_gt);
        settle("gap_b", 2'b11, 2'd0);
        smp(c_gt); push(1'b0, 2'b01, 2'd1);
        settle("gap_commit", 2'b01, 2'd1);

        // Malformed samples
        do_reset();
        repeat (3) smp(c_gt);
        smp(3'b110); push(1'b1, 2'b11, 2'd0);
        repeat (3) smp(c_gt);
        settle("mal_run", 2'b11, 2'd0);
        smp(c_gt); push(1'b0, 2'b01, 2'd1);
        settle("mal_commit", 2'b01, 2'd1);
        smp(3'b111); push(1'b1, 2'b01, 2'd1);
        smp(c_gt);
        settle("mal_stable", 2'b01, 2'd1);
        smp(3'b000); push(1'b1, 2'b01, 2'd1);
        settle("mal_zero", 2'b01, 2'd1);

        // Saturating change counter
        do_reset();
        for (int i = 0; i < 5; i++) begin
            logic [2:0] v;
            logic [1:0] st;
            v  = (i % 2 == 0) ? c_gt : c_lt;
            st = (i % 2 == 0) ? 2'b01 : 2'b10;
            repeat (3) smp(v);
            smp(v); push(1'b0, st, (i >= 2) ? 2'd3 : 2'(i + 1));
            settle("sat", st, (i >= 2) ? 2'd3 : 2'(i + 1));
        end

        // Clear coincident with the 4th matching sample
        repeat (3) smp(c_lt);
        @(negedge clk);
        in_valid = 1'b1;
        {gt, lt, eq} = c_lt;
        clear = 1'b1;
        @(negedge clk);
        clear    = 1'b0;
        in_valid = 1'b0;
        chk("clr_state", int'(out_state), 3);
        chk("clr_count", int'(change_count), 0);
        chk("clr_changed", int'(out_changed), 0);
        repeat (3) smp(c_lt);
        settle("clr_run", 2'b11, 2'd0);
        smp(c_lt); push(1'b0, 2'b10, 2'd1);
        settle("clr_commit", 2'b10, 2'd1);

        // Asynchronous reset mid-run
        repeat (2) smp(c_gt);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_state", int'(out_state), 3);
        chk("arst_count", int'(change_count), 0);
        chk("arst_changed", int'(out_changed), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) smp(c_gt);
        settle("arst_run", 2'b11, 2'd0);
        smp(c_gt); push(1'b0, 2'b01, 2'd1);
        settle("arst_commit", 2'b01, 2'd1);

        repeat (3) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
